// File: rtl/draw_player_car.sv
// Player car sprite compositor: overlays a CAR_W x CAR_H rectangle on the background video.
// Two-stage pipeline. Defining CAR_OUTLINE_EN adds a 1-pixel black outline.
module draw_player_car #(
    parameter int          CAR_W   = 32,
    parameter int          CAR_H   = 64,
    parameter logic [11:0] CAR_RGB = 12'hF00
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] vcount_in,
    input  logic [10:0] hcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    output logic [10:0] vcount_out,
    output logic [10:0] hcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [11:0] W12 = 12'(CAR_W);
    localparam logic [11:0] H12 = 12'(CAR_H);

    // 12-bit compare so base + len can never wrap back onto the screen.
    function automatic logic in_span(input logic [11:0] c, input logic [11:0] base,
                                     input logic [11:0] len);
        return (c >= base) && (c < base + len);
    endfunction

    function automatic logic on_border(input logic [11:0] c, input logic [11:0] base,
                                       input logic [11:0] len);
        return (c == base) || (c == base + len - 12'd1);
    endfunction

    logic [10:0] x_q, y_q;
    logic        car_valid_q;
    logic        vblnk_prev_q;
    logic        latch_d;

    logic [10:0] vcount_p1_q, hcount_p1_q;
    logic        vsync_p1_q, vblnk_p1_q, hsync_p1_q, hblnk_p1_q;
    logic [11:0] rgb_p1_q;
    logic        inside_p1_q, inside_d;
`ifdef CAR_OUTLINE_EN
    logic        border_p1_q, border_d;
`endif
    logic [11:0] rgb_d;

    always_comb begin
        latch_d  = vblnk_in && !vblnk_prev_q;
        inside_d = car_valid_q
                   && in_span({1'b0, hcount_in}, {1'b0, x_q}, W12)
                   && in_span({1'b0, vcount_in}, {1'b0, y_q}, H12);
`ifdef CAR_OUTLINE_EN
        border_d = on_border({1'b0, hcount_in}, {1'b0, x_q}, W12)
                   || on_border({1'b0, vcount_in}, {1'b0, y_q}, H12);
`endif
    end

    always_comb begin
        rgb_d = rgb_p1_q;
        if (hblnk_p1_q || vblnk_p1_q)
            rgb_d = 12'h000;
        else if (inside_p1_q)
`ifdef CAR_OUTLINE_EN
            rgb_d = border_p1_q ? 12'h000 : CAR_RGB;
`else
            rgb_d = CAR_RGB;
`endif
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            car_valid_q  <= 1'b0;
            vblnk_prev_q <= 1'b0;
            vcount_p1_q  <= '0;
            hcount_p1_q  <= '0;
            vsync_p1_q   <= 1'b0;
            vblnk_p1_q   <= 1'b0;
            hsync_p1_q   <= 1'b0;
            hblnk_p1_q   <= 1'b0;
            rgb_p1_q     <= '0;
            inside_p1_q  <= 1'b0;
`ifdef CAR_OUTLINE_EN
            border_p1_q  <= 1'b0;
`endif
            vcount_out   <= '0;
            hcount_out   <= '0;
            vsync_out    <= 1'b0;
            vblnk_out    <= 1'b0;
            hsync_out    <= 1'b0;
            hblnk_out    <= 1'b0;
            rgb_out      <= '0;
        end else begin
            vblnk_prev_q <= vblnk_in;
            // Position only moves at frame start so the car never tears.
            if (latch_d) begin
                x_q         <= xpos;
                y_q         <= ypos;
                car_valid_q <= 1'b1;
            end
            // p1: delayed timing plus inside test
            vcount_p1_q <= vcount_in;
            hcount_p1_q <= hcount_in;
            vsync_p1_q  <= vsync_in;
            vblnk_p1_q  <= vblnk_in;
            hsync_p1_q  <= hsync_in;
            hblnk_p1_q  <= hblnk_in;
            rgb_p1_q    <= rgb_in;
            inside_p1_q <= inside_d;
`ifdef CAR_OUTLINE_EN
            border_p1_q <= border_d;
`endif
            // p2: composited output
            vcount_out  <= vcount_p1_q;
            hcount_out  <= hcount_p1_q;
            vsync_out   <= vsync_p1_q;
            vblnk_out   <= vblnk_p1_q;
            hsync_out   <= hsync_p1_q;
            hblnk_out   <= hblnk_p1_q;
            rgb_out     <= rgb_d;
        end
    end

endmodule

// File: tb/tb_draw_player_car.sv
// Directed bench for draw_player_car; expected values are hand-derived per vector.
module tb_draw_player_car;

    logic        pclk = 1'b0;
    logic        rst;
    logic [10:0] vcount_in, hcount_in, xpos, ypos;
    logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] vcount_out, hcount_out;
    logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
    logic [11:0] rgb_out;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [11:0] CAR = 12'hF00;
`ifdef CAR_OUTLINE_EN
    localparam logic [11:0] EDGE = 12'h000;
`else
    localparam logic [11:0] EDGE = 12'hF00;
`endif

    draw_player_car dut (
        .pclk(pclk), .rst(rst),
        .vcount_in(vcount_in), .hcount_in(hcount_in),
        .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
        .vcount_out(vcount_out), .hcount_out(hcount_out),
        .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_in(input logic [10:0] h, input logic [10:0] v, input logic hb,
                          input logic vb, input logic [11:0] rgb);
        hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
        hsync_in = 1'b0; vsync_in = 1'b0;
    endtask

    // Hold one pixel for two clocks, then compare composited colour and delayed hcount.
    task automatic pix(input string tag, input logic [10:0] h, input logic [10:0] v,
                       input logic hb, input logic vb, input logic [11:0] rgb,
                       input logic [11:0] exp);
        set_in(h, v, hb, vb, rgb);
        step();
        step();
        chk(tag, rgb_out, exp);
        chk({tag, "_hcnt"}, {1'b0, hcount_out}, {1'b0, h});
    endtask

    // vblnk rising edge with the new position present only in the edge cycle.
    task automatic new_frame(input logic [10:0] nx, input logic [10:0] ny);
        set_in(11'd0, 11'd770, 1'b1, 1'b0, 12'h000);
        step();
        vblnk_in = 1'b1; xpos = nx; ypos = ny;
        step();
        xpos = 11'd7; ypos = 11'd7;
        step();
        vblnk_in = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        set_in(11'd5, 11'd6, 1'b0, 1'b0, 12'hABC);
        hsync_in = 1'b1; vsync_in = 1'b1;
        xpos = 11'd100; ypos = 11'd200;
        step();
        step();
        chk("rst_rgb", rgb_out, 12'h000);
        chk("rst_hcnt", {1'b0, hcount_out}, 12'h000);
        chk("rst_vcnt", {1'b0, vcount_out}, 12'h000);
        chk("rst_flags", {8'h0, vsync_out, vblnk_out, hsync_out, hblnk_out}, 12'h000);
        rst = 1'b0;

        // First frame: no latch yet, background passes through.
        pix("f1_a", 11'd100, 11'd200, 1'b0, 1'b0, 12'h0F0, 12'h0F0);
        pix("f1_b", 11'd115, 11'd230, 1'b0, 1'b0, 12'h123, 12'h123);

        new_frame(11'd100, 11'd200);
        pix("f2_tl", 11'd100, 11'd200, 1'b0, 1'b0, 12'h0F0, EDGE);
        pix("f2_br", 11'd131, 11'd263, 1'b0, 1'b0, 12'h0F0, EDGE);
        pix("f2_in", 11'd115, 11'd230, 1'b0, 1'b0, 12'h0F0, CAR);
        pix("f2_l", 11'd99, 11'd200, 1'b0, 1'b0, 12'h0F0, 12'h0F0);
        pix("f2_r", 11'd132, 11'd200, 1'b0, 1'b0, 12'h0F0, 12'h0F0);
        pix("f2_t", 11'd100, 11'd199, 1'b0, 1'b0, 12'h0F0, 12'h0F0);
        pix("f2_b", 11'd100, 11'd264, 1'b0, 1'b0, 12'h0F0, 12'h0F0);
        pix("ol_left", 11'd100, 11'd230, 1'b0, 1'b0, 12'h0F0, EDGE);
        pix("ol_right", 11'd131, 11'd230, 1'b0, 1'b0, 12'h0F0, EDGE);
        pix("ol_inner", 11'd101, 11'd201, 1'b0, 1'b0, 12'h0F0, CAR);

        // Exact 2-cycle latency with a new pixel every clock.
        set_in(11'd110, 11'd210, 1'b0, 1'b0, 12'h00A);
        hsync_in = 1'b1;
        step();
        set_in(11'd50, 11'd211, 1'b0, 1'b0, 12'h00B);
        vsync_in = 1'b1;
        step();
        set_in(11'd51, 11'd212, 1'b0, 1'b0, 12'h00C);
        chk("lat_a_rgb", rgb_out, CAR);
        chk("lat_a_h", {1'b0, hcount_out}, 12'd110);
        chk("lat_a_sync", {10'h0, vsync_out, hsync_out}, 12'b01);
        step();
        chk("lat_b_rgb", rgb_out, 12'h00B);
        chk("lat_b_v", {1'b0, vcount_out}, 12'd211);
        chk("lat_b_sync", {10'h0, vsync_out, hsync_out}, 12'b10);

        // Mid-frame position change must wait for the next frame.
        xpos = 11'd300;
        pix("mid_chg", 11'd500, 11'd300, 1'b0, 1'b0, 12'h0F0, 12'h0F0);
        pix("mid_old", 11'd110, 11'd250, 1'b0, 1'b0, 12'h0F0, CAR);
        pix("mid_new", 11'd310, 11'd250, 1'b0, 1'b0, 12'h0F0, 12'h0F0);
        new_frame(11'd300, 11'd200);
        pix("nf_new", 11'd310, 11'd250, 1'b0, 1'b0, 12'h0F0, CAR);
        pix("nf_old", 11'd110, 11'd250, 1'b0, 1'b0, 12'h0F0, 12'h0F0);

        // Blanking overrides the car.
        xpos = 11'd300; ypos = 11'd200;
        pix("hblnk", 11'd310, 11'd250, 1'b1, 1'b0, 12'h0F0, 12'h000);
        pix("vblnk", 11'd310, 11'd250, 1'b0, 1'b1, 12'h0F0, 12'h000);

        // Car hanging off the bottom-right corner is clipped, not wrapped.
        new_frame(11'd1010, 11'd750);
        pix("clip_in", 11'd1015, 11'd760, 1'b0, 1'b0, 12'h0F0, CAR);
        pix("clip_corner", 11'd1023, 11'd767, 1'b0, 1'b0, 12'h0F0, CAR);
        pix("clip_wrap_h", 11'd5, 11'd760, 1'b0, 1'b0, 12'h0F0, 12'h0F0);
        pix("clip_wrap_v", 11'd1015, 11'd10, 1'b0, 1'b0, 12'h0F0, 12'h0F0);
        pix("clip_wrap_hv", 11'd3, 11'd20, 1'b0, 1'b0, 12'h0F0, 12'h0F0);
        pix("clip_left", 11'd1009, 11'd760, 1'b0, 1'b0, 12'h0F0, 12'h0F0);
        pix("clip_top", 11'd1015, 11'd749, 1'b0, 1'b0, 12'h0F0, 12'h0F0);

        // Mid-frame reset clears the pipeline and hides the car until next latch.
        new_frame(11'd300, 11'd380);
        pix("pre_rst", 11'd310, 11'd400, 1'b0, 1'b0, 12'h0F0, CAR);
        rst = 1'b1;
        step();
        chk("mrst_rgb", rgb_out, 12'h000);
        chk("mrst_hcnt", {1'b0, hcount_out}, 12'h000);
        rst = 1'b0;
        step();
        chk("mrst_gap", rgb_out, 12'h000);
        chk("mrst_gap_h", {1'b0, hcount_out}, 12'h000);
        pix("post_rst", 11'd310, 11'd400, 1'b0, 1'b0, 12'h0F0, 12'h0F0);
        new_frame(11'd300, 11'd380);
        pix("relatch", 11'd310, 11'd400, 1'b0, 1'b0, 12'h0F0, CAR);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
